// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU operations, opcode/funct encodings and multicycle sequencer types.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_ABS = 3'd6
  } t_alu_opcode;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ZERO = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWr   = 4'd4,
    StMemWb   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StAbsExec = 4'd10,
    StBranch  = 4'd11,
    StJmp     = 4'd12,
    StHalt    = 4'd13
  } t_mc_state;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  typedef struct packed {
    logic        valid;
    t_alu_opcode op;
  } t_alu_dec;

  // All-zero value is the idle strobe set with ALU_ADD selected.
  typedef struct packed {
    logic        mem_req;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    t_alu_opcode alu;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
  } t_mc_ctrl;

  function automatic t_alu_dec decode_funct(input logic [5:0] funct);
    t_alu_dec r;
    r.valid = 1'b1;
    r.op    = ALU_ADD;
    case (funct)
      FN_ADD:  r.op = ALU_ADD;
      FN_SUB:  r.op = ALU_SUB;
      FN_AND:  r.op = ALU_AND;
      FN_OR:   r.op = ALU_OR;
      FN_XOR:  r.op = ALU_XOR;
      FN_SLT:  r.op = ALU_SLT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_multicycle_fsm_if.sv
// Handshake with the unified variable-latency memory.
interface mips_multicycle_fsm_if;
  logic mem_req;
  logic mem_ready;
  logic MemRead;
  logic MemWrite;
  logic IorD;

  modport master (output mem_req, output MemRead, output MemWrite, output IorD, input mem_ready);
  modport slave  (input mem_req, input MemRead, input MemWrite, input IorD, output mem_ready);
endinterface

// File: rtl/mips_multicycle_fsm.sv
// Multicycle MIPS control sequencer: one datapath step per state, memory handshake with timeout.
module mips_multicycle_fsm
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  mips_multicycle_fsm_if.master        mem_bus,
  input  logic [5:0]                   opcode,
  input  logic [5:0]                   funct,
  input  logic                         zero,
  output logic                         IRWrite,
  output logic                         PCWrite,
  output logic                         PCWriteCond,
  output logic [1:0]                   PCSrc,
  output logic                         ALUSrcA,
  output logic [1:0]                   ALUSrcB,
  output t_alu_opcode                  alu_control,
  output logic                         RegDst,
  output logic                         RegWrite,
  output logic                         MemToReg,
  output logic                         err_illegal,
  output logic                         err_timeout,
  output t_mc_state                    state_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  t_mc_state        r_state, w_state_d;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic             r_err_illegal, w_err_illegal_d;
  logic             r_err_timeout, w_err_timeout_d;
  logic             w_mem_state;
  t_mc_ctrl         w_ctrl, w_out;
  t_alu_dec         w_alu_dec;

  // zero only qualifies PCWriteCond inside the datapath; the sequencer never branches on it.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  assign w_alu_dec = decode_funct(funct);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StFetch;
      r_wait        <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_wait        <= w_wait_d;
      r_err_illegal <= w_err_illegal_d;
      r_err_timeout <= w_err_timeout_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_wait_d        = '0;
    w_err_illegal_d = r_err_illegal;
    w_err_timeout_d = r_err_timeout;
    w_mem_state     = 1'b0;
    w_ctrl          = '0;
    w_ctrl.alu      = ALU_ADD;

    unique case (r_state)
      StFetch: begin
        w_mem_state      = 1'b1;
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.pc_src    = PCSRC_ALU;
        if (mem_bus.mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_state_d       = StDecode;
        end
      end
      StDecode: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:      w_state_d = StMemAddr;
          OP_RTYPE:          w_state_d = (funct == FN_ZERO) ? StFetch : StRExec;
          OP_ADDI, OP_ADDIU: w_state_d = StIExec;
          OP_BEQ:            w_state_d = StBranch;
          OP_JUMP:           w_state_d = StJmp;
          OP_ABS:            w_state_d = StAbsExec;
          default: begin
            w_err_illegal_d = 1'b1;
            w_state_d       = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_state_d        = (opcode == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        w_mem_state     = 1'b1;
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (mem_bus.mem_ready) w_state_d = StMemWb;
      end
      StMemWr: begin
        w_mem_state      = 1'b1;
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (mem_bus.mem_ready) w_state_d = StFetch;
      end
      StMemWb: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_state_d         = StFetch;
      end
      StRExec: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu       = w_alu_dec.op;
        if (w_alu_dec.valid) begin
          w_state_d = StRWb;
        end else begin
          w_err_illegal_d = 1'b1;
          w_state_d       = StFetch;
        end
      end
      StRWb: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_state_d        = StFetch;
      end
      StIExec: begin
        w_ctrl.alu_src_b = SRCB_IMM;
        w_state_d        = StIWb;
      end
      StIWb: begin
        w_ctrl.reg_write = 1'b1;
        w_state_d        = StFetch;
      end
      StAbsExec: begin
        w_ctrl.alu = ALU_ABS;
        w_state_d  = StIWb;
      end
      StBranch: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_REGB;
        w_ctrl.alu           = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_src        = PCSRC_ALUOUT;
        w_state_d            = StFetch;
      end
      StJmp: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_state_d       = StFetch;
      end
      StHalt: w_state_d = StHalt;
      default: w_state_d = StFetch;
    endcase

    // Leaving a memory state leaves w_wait_d at zero, so every access starts a fresh count.
    if (w_mem_state && !mem_bus.mem_ready) begin
      if (r_wait == WaitW'(MEM_TIMEOUT - 1)) begin
        w_err_timeout_d = 1'b1;
        w_state_d       = StHalt;
      end else begin
        w_wait_d = r_wait + 1'b1;
      end
    end
  end

  assign w_out = rst ? '0 : w_ctrl;

  assign mem_bus.mem_req  = w_out.mem_req;
  assign mem_bus.MemRead  = w_out.mem_read;
  assign mem_bus.MemWrite = w_out.mem_write;
  assign mem_bus.IorD     = w_out.iord;
  assign IRWrite          = w_out.ir_write;
  assign PCWrite          = w_out.pc_write;
  assign PCWriteCond      = w_out.pc_write_cond;
  assign PCSrc            = w_out.pc_src;
  assign ALUSrcA          = w_out.alu_src_a;
  assign ALUSrcB          = w_out.alu_src_b;
  assign alu_control      = w_out.alu;
  assign RegDst           = w_out.reg_dst;
  assign RegWrite         = w_out.reg_write;
  assign MemToReg         = w_out.mem_to_reg;
  assign err_illegal      = r_err_illegal;
  assign err_timeout      = r_err_timeout;
  assign state_o          = r_state;

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Directed per-cycle vectors for the multicycle sequencer, plus reset/timeout corner sequences.
module tb_mips_multicycle_fsm;
  import mips_pkg::*;

  // Strobe bundle order: req rd wr iord irw pcw pcwc | pcsrc | srca | srcb | alu | regdst regw m2r
  typedef struct packed {
    logic [6:0]  strb;
    logic [1:0]  pcsrc;
    logic        srca;
    logic [1:0]  srcb;
    t_alu_opcode alu;
    logic [2:0]  wb;
  } t_exp;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    t_mc_state  st;
    t_exp       x;
    logic       ei;
    logic       et;
  } t_vec;

  localparam t_exp XIdle      = {7'b0000000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b000};
  localparam t_exp XFetchGo   = {7'b1100110, 2'd0, 1'b0, 2'd1, ALU_ADD, 3'b000};
  localparam t_exp XFetchWait = {7'b1100000, 2'd0, 1'b0, 2'd1, ALU_ADD, 3'b000};
  localparam t_exp XDecode    = {7'b0000000, 2'd0, 1'b0, 2'd3, ALU_ADD, 3'b000};
  localparam t_exp XMemAddr   = {7'b0000000, 2'd0, 1'b1, 2'd2, ALU_ADD, 3'b000};
  localparam t_exp XMemRd     = {7'b1101000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b000};
  localparam t_exp XMemWr     = {7'b1011000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b000};
  localparam t_exp XMemWb     = {7'b0000000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b011};
  localparam t_exp XRExecAdd  = {7'b0000000, 2'd0, 1'b1, 2'd0, ALU_ADD, 3'b000};
  localparam t_exp XRExecXor  = {7'b0000000, 2'd0, 1'b1, 2'd0, ALU_XOR, 3'b000};
  localparam t_exp XRWb       = {7'b0000000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b110};
  localparam t_exp XIExec     = {7'b0000000, 2'd0, 1'b0, 2'd2, ALU_ADD, 3'b000};
  localparam t_exp XIWb       = {7'b0000000, 2'd0, 1'b0, 2'd0, ALU_ADD, 3'b010};
  localparam t_exp XAbs       = {7'b0000000, 2'd0, 1'b0, 2'd0, ALU_ABS, 3'b000};
  localparam t_exp XBranch    = {7'b0000001, 2'd1, 1'b1, 2'd0, ALU_SUB, 3'b000};
  localparam t_exp XJmp       = {7'b0000010, 2'd2, 1'b0, 2'd0, ALU_ADD, 3'b000};

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        IRWrite, PCWrite, PCWriteCond, ALUSrcA, RegDst, RegWrite, MemToReg;
  logic [1:0]  PCSrc, ALUSrcB;
  t_alu_opcode alu_control;
  logic        err_illegal, err_timeout;
  t_mc_state   state_o;
  t_exp        act;

  int n_total = 0;
  int n_bad   = 0;
  t_vec vecs[$];

  mips_multicycle_fsm_if bus ();

  mips_multicycle_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_bus     (bus),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSrc       (PCSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .alu_control (alu_control),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .MemToReg    (MemToReg),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .state_o     (state_o)
  );

  assign act = {bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD, IRWrite, PCWrite, PCWriteCond,
                PCSrc, ALUSrcA, ALUSrcB, alu_control, RegDst, RegWrite, MemToReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input t_mc_state st, input t_exp x, input logic ei,
                     input logic et);
    t_vec v;
    v = '{rst: r, op: op, fn: fn, z: z, rdy: rdy, st: st, x: x, ei: ei, et: et};
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge and check that cycle's state and strobes.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input t_mc_state st, input t_exp x, input logic ei,
                      input logic et);
    @(negedge clk);
    rst = r;
    opcode = op;
    funct = fn;
    zero = z;
    bus.mem_ready = rdy;
    #1;
    n_total++;
    if (state_o !== st || act !== x || err_illegal !== ei || err_timeout !== et) begin
      n_bad++;
      $display("FAIL cycle_check #%0d: got state=%s ctrl=%h ill=%b to=%b, want state=%s ctrl=%h ill=%b to=%b",
               n_total, state_o.name(), act, err_illegal, err_timeout, st.name(), x, ei, et);
    end
  endtask

  task automatic pulse_rst_edge();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);

    add(1, OP_RTYPE, FN_ZERO, 0, 1, StFetch, XIdle, 0, 0);
    // ADD: 4 cycles, PCWrite on 1, RegWrite on 4
    add(0, OP_RTYPE, FN_ADD, 0, 1, StFetch,   XFetchGo,  0, 0);
    add(0, OP_RTYPE, FN_ADD, 0, 1, StDecode,  XDecode,   0, 0);
    add(0, OP_RTYPE, FN_ADD, 0, 1, StRExec,   XRExecAdd, 0, 0);
    add(0, OP_RTYPE, FN_ADD, 0, 1, StRWb,     XRWb,      0, 0);
    // LW with three wait cycles in MEM_RD; ready in MEM_ADDR is ignored
    add(0, OP_LW, 6'h00, 0, 1, StFetch,   XFetchGo, 0, 0);
    add(0, OP_LW, 6'h00, 0, 1, StDecode,  XDecode,  0, 0);
    add(0, OP_LW, 6'h00, 0, 1, StMemAddr, XMemAddr, 0, 0);
    add(0, OP_LW, 6'h00, 0, 0, StMemRd,   XMemRd,   0, 0);
    add(0, OP_LW, 6'h00, 0, 0, StMemRd,   XMemRd,   0, 0);
    add(0, OP_LW, 6'h00, 0, 0, StMemRd,   XMemRd,   0, 0);
    add(0, OP_LW, 6'h00, 0, 1, StMemRd,   XMemRd,   0, 0);
    add(0, OP_LW, 6'h00, 0, 0, StMemWb,   XMemWb,   0, 0);
    // BEQ taken then not taken: identical strobes
    add(0, OP_BEQ, 6'h00, 0, 1, StFetch,  XFetchGo, 0, 0);
    add(0, OP_BEQ, 6'h00, 0, 1, StDecode, XDecode,  0, 0);
    add(0, OP_BEQ, 6'h00, 1, 1, StBranch, XBranch,  0, 0);
    add(0, OP_BEQ, 6'h00, 0, 1, StFetch,  XFetchGo, 0, 0);
    add(0, OP_BEQ, 6'h00, 0, 1, StDecode, XDecode,  0, 0);
    add(0, OP_BEQ, 6'h00, 0, 1, StBranch, XBranch,  0, 0);
    // Illegal opcode, then a jump proceeds with the sticky flag
    add(0, 6'h3F, 6'h00, 0, 1, StFetch,  XFetchGo, 0, 0);
    add(0, 6'h3F, 6'h00, 0, 1, StDecode, XDecode,  0, 0);
    add(0, OP_JUMP, 6'h00, 0, 1, StFetch,  XFetchGo, 1, 0);
    add(0, OP_JUMP, 6'h00, 0, 1, StDecode, XDecode,  1, 0);
    add(0, OP_JUMP, 6'h00, 0, 1, StJmp,    XJmp,     1, 0);
    // SW, zero-wait
    add(0, OP_SW, 6'h00, 0, 1, StFetch,   XFetchGo, 1, 0);
    add(0, OP_SW, 6'h00, 0, 1, StDecode,  XDecode,  1, 0);
    add(0, OP_SW, 6'h00, 0, 1, StMemAddr, XMemAddr, 1, 0);
    add(0, OP_SW, 6'h00, 0, 1, StMemWr,   XMemWr,   1, 0);
    // ADDI and ABS share the I_WB writeback
    add(0, OP_ADDI, 6'h00, 0, 1, StFetch,  XFetchGo, 1, 0);
    add(0, OP_ADDI, 6'h00, 0, 1, StDecode, XDecode,  1, 0);
    add(0, OP_ADDI, 6'h00, 0, 1, StIExec,  XIExec,   1, 0);
    add(0, OP_ADDI, 6'h00, 0, 1, StIWb,    XIWb,     1, 0);
    add(0, OP_ABS, 6'h00, 0, 1, StFetch,   XFetchGo, 1, 0);
    add(0, OP_ABS, 6'h00, 0, 1, StDecode,  XDecode,  1, 0);
    add(0, OP_ABS, 6'h00, 0, 1, StAbsExec, XAbs,     1, 0);
    add(0, OP_ABS, 6'h00, 0, 1, StIWb,     XIWb,     1, 0);
    // NOP (2 cycles) followed by XOR
    add(0, OP_RTYPE, FN_ZERO, 0, 1, StFetch,  XFetchGo,  1, 0);
    add(0, OP_RTYPE, FN_ZERO, 0, 1, StDecode, XDecode,   1, 0);
    add(0, OP_RTYPE, FN_XOR,  0, 1, StFetch,  XFetchGo,  1, 0);
    add(0, OP_RTYPE, FN_XOR,  0, 1, StDecode, XDecode,   1, 0);
    add(0, OP_RTYPE, FN_XOR,  0, 1, StRExec,  XRExecXor, 1, 0);
    add(0, OP_RTYPE, FN_XOR,  0, 1, StRWb,    XRWb,      1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].st, vecs[i].x,
           vecs[i].ei, vecs[i].et);
    end

    // Unknown funct: flagged in R_EXEC, no writeback
    pulse_rst_edge();
    step(1, OP_RTYPE, 6'h3F, 0, 1, StFetch,  XIdle,     0, 0);
    step(0, OP_RTYPE, 6'h3F, 0, 1, StFetch,  XFetchGo,  0, 0);
    step(0, OP_RTYPE, 6'h3F, 0, 1, StDecode, XDecode,   0, 0);
    step(0, OP_RTYPE, 6'h3F, 0, 1, StRExec,  XRExecAdd, 0, 0);

    // Fetch starved for 16 cycles -> HALT with err_timeout, ready afterwards ignored
    for (int k = 0; k < 16; k++) begin
      step(0, OP_RTYPE, 6'h00, 0, 0, StFetch, XFetchWait, 1, 0);
    end
    step(0, OP_RTYPE, 6'h00, 0, 0, StHalt, XIdle, 1, 1);
    step(0, OP_RTYPE, 6'h00, 0, 1, StHalt, XIdle, 1, 1);
    pulse_rst_edge();
    step(1, OP_RTYPE, 6'h00, 0, 1, StFetch, XIdle, 0, 0);

    // Reset during MEM_WR: strobes drop at once, FETCH with cleared flags next cycle
    step(0, 6'h3F, 6'h00, 0, 1, StFetch,   XFetchGo, 0, 0);
    step(0, 6'h3F, 6'h00, 0, 1, StDecode,  XDecode,  0, 0);
    step(0, OP_SW, 6'h00, 0, 1, StFetch,   XFetchGo, 1, 0);
    step(0, OP_SW, 6'h00, 0, 1, StDecode,  XDecode,  1, 0);
    step(0, OP_SW, 6'h00, 0, 0, StMemAddr, XMemAddr, 1, 0);
    step(0, OP_SW, 6'h00, 0, 0, StMemWr,   XMemWr,   1, 0);
    step(1, OP_SW, 6'h00, 0, 0, StMemWr,   XIdle,    1, 0);
    step(0, OP_SW, 6'h00, 0, 0, StFetch,   XFetchWait, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
